// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: round-robin sharing of one ALU among NUM_REQ requesters.
// Owner tags travel alongside the ALU latency to steer the registered response.
module alu_rr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int C_WIDTH   = 4,
    parameter int RES_WIDTH = 16,
    parameter int ALU_LAT   = 1
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       hold,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ-1:0]         req_mode,
    input  logic [NUM_REQ*C_WIDTH-1:0] req_cmd,
    input  logic [NUM_REQ*2-1:0]       req_inp_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_opa,
    input  logic [NUM_REQ*WIDTH-1:0]   req_opb,
    input  logic [NUM_REQ-1:0]         req_cin,
    output logic                       alu_ce,
    output logic                       alu_mode,
    output logic [1:0]                 alu_inp_valid,
    output logic [C_WIDTH-1:0]         alu_cmd,
    output logic [WIDTH-1:0]           alu_opa,
    output logic [WIDTH-1:0]           alu_opb,
    output logic                       alu_cin,
    input  logic [RES_WIDTH-1:0]       alu_res,
    input  logic                       alu_cout,
    input  logic                       alu_oflow,
    input  logic                       alu_g,
    input  logic                       alu_l,
    input  logic                       alu_e,
    input  logic                       alu_err,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [RES_WIDTH-1:0]       rsp_res,
    output logic [5:0]                 rsp_flags,
    output logic [2:0]                 inflight
);

    localparam int IW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DEPTH = ALU_LAT + 1;

    typedef struct packed {
        logic          vld;
        logic [IW-1:0] own;
    } tag_t;

    logic [IW-1:0]      ptr;
    logic [IW-1:0]      ptr_next;
    logic [IW-1:0]      win;
    logic [IW-1:0]      idx;
    logic               found;
    logic               fire;
    int                 scan;
    logic [IW-1:0]      issue_own;
    tag_t               tag_q [DEPTH];
    tag_t               tail;
    logic [NUM_REQ-1:0] rsp_hot;

    logic               sel_mode;
    logic [1:0]         sel_iv;
    logic [C_WIDTH-1:0] sel_cmd;
    logic [WIDTH-1:0]   sel_opa;
    logic [WIDTH-1:0]   sel_opb;
    logic               sel_cin;

    // Scan from ptr upward, wrapping, and take the first valid requester.
    always_comb begin
        found = 1'b0;
        win   = ptr;
        scan  = 0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = int'(ptr) + k;
            if (scan >= NUM_REQ) begin
                scan = scan - NUM_REQ;
            end
            idx = IW'(scan);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign fire = found & ~hold & RST;

    always_comb begin
        req_ready = '0;
        if (fire) begin
            req_ready[win] = 1'b1;
        end
    end

    always_comb begin
        ptr_next = ptr;
        if (fire) begin
            if (int'(win) == NUM_REQ - 1) begin
                ptr_next = '0;
            end else begin
                ptr_next = win + IW'(1);
            end
        end
    end

    // One-hot AND-OR mux of the winning payload.
    always_comb begin
        sel_mode = 1'b0;
        sel_iv   = '0;
        sel_cmd  = '0;
        sel_opa  = '0;
        sel_opb  = '0;
        sel_cin  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                sel_mode = req_mode[i];
                sel_iv   = req_inp_valid[i*2 +: 2];
                sel_cmd  = req_cmd[i*C_WIDTH +: C_WIDTH];
                sel_opa  = req_opa[i*WIDTH +: WIDTH];
                sel_opb  = req_opb[i*WIDTH +: WIDTH];
                sel_cin  = req_cin[i];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_next;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            alu_ce        <= 1'b0;
            alu_mode      <= 1'b0;
            alu_inp_valid <= '0;
            alu_cmd       <= '0;
            alu_opa       <= '0;
            alu_opb       <= '0;
            alu_cin       <= 1'b0;
            issue_own     <= '0;
        end else if (fire) begin
            alu_ce        <= 1'b1;
            alu_mode      <= sel_mode;
            alu_inp_valid <= sel_iv;
            alu_cmd       <= sel_cmd;
            alu_opa       <= sel_opa;
            alu_opb       <= sel_opb;
            alu_cin       <= sel_cin;
            issue_own     <= win;
        end else begin
            alu_ce        <= 1'b0;
            alu_inp_valid <= '0;
        end
    end

    // alu_ce doubles as the valid bit of the issue-stage tag.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int s = 0; s < DEPTH; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            tag_q[0].vld <= alu_ce;
            tag_q[0].own <= issue_own;
            for (int s = 1; s < DEPTH; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    assign tail = tag_q[DEPTH-1];

    always_comb begin
        rsp_hot = '0;
        rsp_hot[tail.own] = 1'b1;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rsp_valid <= '0;
            rsp_res   <= '0;
            rsp_flags <= '0;
        end else if (tail.vld) begin
            rsp_valid <= rsp_hot;
            rsp_res   <= alu_res;
            rsp_flags <= {alu_err, alu_cout, alu_oflow, alu_g, alu_l, alu_e};
        end else begin
            rsp_valid <= '0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            inflight <= '0;
        end else begin
            case ({fire, tail.vld})
                2'b10:   inflight <= inflight + 3'd1;
                2'b01:   inflight <= inflight - 3'd1;
                default: inflight <= inflight;
            endcase
        end
    end

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
- Shares one ALU datapath between NUM_REQ requesters using round-robin arbitration.
- Each requester has a valid/ready request port.
- The winning request is registered onto the ALU input bus: CE, MODE, INP_VALID, CMD, OPA, OPB, CIN.
- A tag pipeline tracks the owner of each in-flight operation; the ALU result and flags return to that owner as a registered, one-hot response.
- Sits between requester agents/masters and the ALU DUT; the bench drives it through the ALU interface signals.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 8, operand width.
- C_WIDTH, 4, command width.
- RES_WIDTH, 16, result width (2*WIDTH).
- ALU_LAT, 1, number of clock edges from the edge where the ALU samples its inputs to the edge where RES/flags are valid (1..4).

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous reset, active-low.
- hold  in  1  when high, no new grants; in-flight operations complete.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant/accept (one-hot or zero).
- req_mode  in  NUM_REQ  per-requester MODE.
- req_cmd  in  NUM_REQ*C_WIDTH  packed CMD; requester i occupies slice [i*C_WIDTH +: C_WIDTH].
- req_inp_valid  in  NUM_REQ*2  packed INP_VALID.
- req_opa  in  NUM_REQ*WIDTH  packed OPA.
- req_opb  in  NUM_REQ*WIDTH  packed OPB.
- req_cin  in  NUM_REQ  per-requester CIN.
- alu_ce  out  1  ALU CE.
- alu_mode  out  1  ALU MODE.
- alu_inp_valid  out  2  ALU INP_VALID.
- alu_cmd  out  C_WIDTH  ALU CMD.
- alu_opa  out  WIDTH  ALU OPA.
- alu_opb  out  WIDTH  ALU OPB.
- alu_cin  out  1  ALU CIN.
- alu_res  in  RES_WIDTH  ALU RES.
- alu_cout, alu_oflow, alu_g, alu_l, alu_e, alu_err  in  1 each  ALU flags.
- rsp_valid  out  NUM_REQ  one-hot response strobe to the owning requester.
- rsp_res  out  RES_WIDTH  returned result (shared bus).
- rsp_flags  out  6  {err, cout, oflow, g, l, e}.
- inflight  out  3  count of operations issued but not yet responded.

Behaviour:
- Reset (RST low, asynchronous), all outputs and state forced to zero:
  - alu_* = 0, rsp_* = 0, inflight = 0, req_ready = 0.
  - RR pointer = 0; all tag pipeline stages invalid.
  - In-flight operations are dropped; no response is issued for them after RST releases.
- Arbitration (combinational each cycle):
  - If hold = 0, scan req_valid starting at index ptr and wrapping modulo NUM_REQ; the first asserted index wins.
  - req_ready[win] = 1; all other bits 0. If hold = 1 or no req_valid, req_ready = 0.
- Handshake:
  - Transfer occurs at an edge where req_valid[i] & req_ready[i].
  - Requesters hold all payload stable while valid and not ready.
  - Deasserting valid before a grant is legal and loses nothing.
- Pointer: on a transfer from index i, ptr <= (i+1) mod NUM_REQ. Otherwise ptr is unchanged.
- Issue register, at a transfer edge:
  - alu_ce <= 1.
  - alu_mode, alu_cmd, alu_inp_valid, alu_opa, alu_opb, alu_cin <= winner's slice.
- Idle register, at an edge with no transfer:
  - alu_ce <= 0 and alu_inp_valid <= 0.
  - alu_mode, alu_cmd, alu_opa, alu_opb, alu_cin hold their last values.
- Throughput: one issue per cycle maximum, back-to-back across requesters allowed.
- Tag pipeline:
  - ALU_LAT+1 stages of {valid, owner index}; stage 0 loads at the transfer edge and advances every edge.
  - When the last stage is valid, at the next edge: rsp_valid <= onehot(owner), rsp_res <= alu_res, rsp_flags <= ALU flags.
  - Otherwise rsp_valid <= 0 and rsp_res/rsp_flags hold their values.
- Latency: handshake at edge E, rsp_valid high for exactly one cycle after edge E+ALU_LAT+2.
- Responses have no backpressure; requesters must accept them.
- inflight:
  - +1 on transfer, -1 when rsp_valid is set.
  - Both at the same edge: unchanged. Never exceeds ALU_LAT+2.
- hold:
  - Asserting hold mid-stream blocks new grants from the same cycle.
  - Pipeline drains normally; the pointer is frozen.
- Payload pass-through: requests with INP_VALID = 2'b00 or an illegal CMD are still issued. alu_err is returned unmodified in rsp_flags[5].

Test Plan:
- Single request, ALU_LAT=1:
  - Stimulus: req 2 issues MODE=1, CMD=0 (ADD), OPA=8'h0F, OPB=8'h01, INP_VALID=2'b11.
  - Required: req_ready[2] high in the request cycle; alu_ce=1 and alu_opa=8'h0F after that edge.
  - Required: rsp_valid=4'b0100 after 3 edges, rsp_res=16'h0010.
- All four requesters valid continuously from reset:
  - Required grant order 0,1,2,3,0,…, one per cycle.
  - Required: responses arrive in the same order; inflight holds at 3 in steady state.
- Fairness after a grant:
  - Stimulus: ptr=2 after a grant to 1; req_valid=4'b0011.
  - Required: grant goes to 0, then to 1.
- hold during a burst:
  - Stimulus: hold=1 asserted after 2 issues.
  - Required: req_ready=0; two responses still arrive; inflight reaches 0; alu_ce=0.
  - Required: after hold=0, the grant resumes at the saved pointer.
- Reset mid-operation:
  - Stimulus: RST low with inflight=2.
  - Required: all outputs 0 immediately (asynchronous); no rsp_valid after release.
- Error pass-through:
  - Stimulus: request with INP_VALID=2'b00; bench ALU model drives ERR=1.
  - Required: rsp_flags[5]=1 to the correct requester; pointer advances normally.
